// File: rtl/rptr_empty.sv
// Read-side pointer, synchroniser and empty/level flags
// for the dual-clock FIFO.
module rptr_empty #(
  parameter int ADDRSIZE      = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   wptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  typedef logic [ADDRSIZE:0] ptr_t;

  localparam ptr_t THRESH = ptr_t'(AEMPTY_THRESH);

  ptr_t rbin_q, rptr_q;
  ptr_t rq1_q, rq2_q;
  ptr_t rlevel_q, rlevel_d;
  logic rempty_q, rempty_d;
  logic raempty_q, raempty_d;
  logic runder_q, runder_d;

  ptr_t rbnext, rgnext, wbin_s;
  logic rd_en;

  // Two-flop synchroniser for the write Gray pointer.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rq1_q <= '0;
      rq2_q <= '0;
    end else begin
      rq1_q <= wptr;
      rq2_q <= rq1_q;
    end
  end

  // Next pointer; a read while empty is dropped.
  always_comb begin
    rd_en  = rinc & ~rempty_q;
    rbnext = rbin_q + ptr_t'(rd_en);
    rgnext = (rbnext >> 1) ^ rbnext;
  end

  // Gray-to-binary of the synchronised write pointer.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin_s[i] = ^(rq2_q >> i);
    end
  end

  // Next flags and level from the next read pointer.
  always_comb begin
    rlevel_d  = wbin_s - rbnext;
    rempty_d  = (rgnext == rq2_q);
    raempty_d = (rlevel_d <= THRESH);
    runder_d  = runder_q | (rinc & rempty_q);
  end

  // Pointer, flag and level registers.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      runder_q  <= 1'b0;
    end else begin
      rbin_q    <= rbnext;
      rptr_q    <= rgnext;
      rlevel_q  <= rlevel_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
      runder_q  <= runder_d;
    end
  end

  assign raddr      = rbin_q[ADDRSIZE-1:0];
  assign rptr       = rptr_q;
  assign rlevel     = rlevel_q;
  assign rempty     = rempty_q;
  assign raempty    = raempty_q;
  assign runderflow = runder_q;

endmodule
